// File: rtl/aud_pkg.sv
// aud_pkg: constants and capture state encoding shared by the audio PWM player/capture blocks
package aud_pkg;
    localparam int AUD_DATA_WIDTH  = 8;
    localparam int MUSIC_LEN       = 156249;
    localparam int AUD_MAX_SAMPLES = MUSIC_LEN;
    typedef enum logic [1:0] {IDLE, ARM, MEASURE, GAP} cap_state_e;
endpackage

// File: rtl/aud_sample_fifo.sv
// aud_sample_fifo: first-word-fall-through sample FIFO; a pop on full frees the slot for a same-cycle push
module aud_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty    = wr_ptr == rd_ptr;
    assign full     = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
    end
endmodule

// File: rtl/aud_pwm_capture.sv
// aud_pwm_capture: measures PWM high time per fixed window and streams one duty sample per window
module aud_pwm_capture
    import aud_pkg::*;
#(
    parameter int DATA_WIDTH  = AUD_DATA_WIDTH,
    parameter int GAP_CYCLES  = 1,
    parameter int MAX_SAMPLES = AUD_MAX_SAMPLES,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  pwm_i,
    output logic [DATA_WIDTH-1:0] sample_o,
    output logic                  sample_valid_o,
    input  logic                  sample_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o
);
    localparam int CW = $clog2(MAX_SAMPLES + 1);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_SAMPLES - 1);
    cap_state_e state;
    logic pwm_m, pwm_s, pwm_d;
    logic [DATA_WIDTH-1:0] phase, sample, fifo_data;
    logic [DATA_WIDTH:0] high_cnt, high_nxt, high_dec;
    logic [CW-1:0] smp_cnt;
    logic [GW-1:0] gap_cnt;
    logic push, full, empty, clr;
    assign high_nxt = high_cnt + {{DATA_WIDTH{1'b0}}, pwm_s};
    assign high_dec = high_nxt - (DATA_WIDTH+1)'(1);
    // player drives D+1 high clocks for duty D, so subtract one and floor at zero
    assign sample   = high_nxt == '0 ? '0 : high_dec[DATA_WIDTH-1:0];
    assign push     = state == MEASURE && &phase && !stop_i;
    assign clr      = state == IDLE && start_i && !stop_i;
    assign busy_o   = state != IDLE;
    assign sample_valid_o = !empty;
    assign sample_o = empty ? '0 : fifo_data;
    aud_sample_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_ni(rst_ni),
        .clr(clr),
        .push(push),
        .data_in(sample),
        .full(full),
        .pop(sample_ready_i),
        .data_out(fifo_data),
        .empty(empty)
    );
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            {pwm_m, pwm_s, pwm_d} <= '0;
            state      <= IDLE;
            phase      <= '0;
            high_cnt   <= '0;
            smp_cnt    <= '0;
            gap_cnt    <= '0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            pwm_m  <= pwm_i;
            pwm_s  <= pwm_m;
            pwm_d  <= pwm_s;
            done_o <= 1'b0;
            if (push && full && !(sample_ready_i && !empty)) overflow_o <= 1'b1;
            if (state != IDLE && stop_i) state <= IDLE;
            else case (state)
                IDLE: if (clr) begin
                    state      <= ARM;
                    overflow_o <= 1'b0;
                    smp_cnt    <= '0;
                end
                ARM: if (pwm_s && !pwm_d) begin
                    high_cnt <= (DATA_WIDTH+1)'(1);
                    phase    <= DATA_WIDTH'(1);
                    state    <= MEASURE;
                end
                MEASURE: if (&phase) begin
                    smp_cnt  <= smp_cnt + CW'(1);
                    phase    <= '0;
                    high_cnt <= '0;
                    gap_cnt  <= '0;
                    if (smp_cnt == CNT_LAST) begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                    end else if (GAP_CYCLES != 0) state <= GAP;
                end else begin
                    phase    <= phase + DATA_WIDTH'(1);
                    high_cnt <= high_nxt;
                end
                GAP: if (gap_cnt == GAP_LAST) state <= MEASURE;
                     else gap_cnt <= gap_cnt + GW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aud_pwm_capture.sv
// tb_aud_pwm_capture: directed loopback, overflow, stop and reset checks with a player-style PWM source
module tb_aud_pwm_capture;
    localparam int DW = 8;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic start_i = 1'b0;
    logic stop_i = 1'b0;
    logic pwm_i = 1'b0;
    logic sample_ready_i = 1'b0;
    logic [DW-1:0] sample_o;
    logic sample_valid_o, busy_o, done_o, overflow_o;
    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [DW-1:0] got[$];

    always #5 clk = ~clk;

    aud_pwm_capture #(
        .DATA_WIDTH(DW),
        .GAP_CYCLES(1),
        .MAX_SAMPLES(6),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_ni(rst_ni),
        .start_i(start_i),
        .stop_i(stop_i),
        .pwm_i(pwm_i),
        .sample_o(sample_o),
        .sample_valid_o(sample_valid_o),
        .sample_ready_i(sample_ready_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .overflow_o(overflow_o)
    );

    always @(negedge clk) begin
        if (sample_valid_o && sample_ready_i) got.push_back(sample_o);
        if (done_o) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run();
        got.delete();
        done_cnt = 0;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(2);
    endtask

    // one player window: D+1 high clocks, rest low, reload slot low
    task automatic play(input int d, input bit poke);
        for (int c = 0; c < 257; c++) begin
            pwm_i = c <= d && c < 256;
            start_i = poke && c == 100;
            tick(1);
        end
        start_i = 1'b0;
    endtask

    task automatic play_seq(input int d[6], input int n, input int poke);
        for (int i = 0; i < n; i++) play(d[i], i == poke);
        pwm_i = 1'b0;
    endtask

    task automatic check_got(input string tag, input int exp[6], input int n);
        check({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++)
            check(tag, i < got.size() ? 32'(got[i]) : 32'hFFFF_FFFF, exp[i]);
    endtask

    initial begin
        tick(2);
        check("rst_sample", sample_o, 0);
        check("rst_valid", sample_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ovf", overflow_o, 0);
        rst_ni = 1'b1;
        tick(2);

        start_i = 1'b1;
        stop_i = 1'b1;
        tick(1);
        check("start_stop_idle", busy_o, 0);
        start_i = 1'b0;
        stop_i = 1'b0;
        tick(2);
        check("start_stop_idle_hold", busy_o, 0);

        sample_ready_i = 1'b1;
        start_run();
        check("busy_after_start", busy_o, 1);
        play_seq('{0, 1, 128, 255, 64, 200}, 6, 1);
        tick(10);
        check_got("loopback", '{0, 1, 128, 255, 64, 200}, 6);
        check("loopback_done", done_cnt, 1);
        check("loopback_busy", busy_o, 0);
        check("loopback_ovf", overflow_o, 0);

        start_run();
        pwm_i = 1'b1;
        tick(1);
        pwm_i = 1'b0;
        tick(256);
        pwm_i = 1'b1;
        tick(257);
        pwm_i = 1'b0;
        tick(257 * 4 + 10);
        check_got("pulse_hold", '{0, 255, 0, 0, 0, 0}, 6);
        check("pulse_hold_done", done_cnt, 1);

        sample_ready_i = 1'b0;
        start_run();
        play_seq('{10, 20, 30, 40, 50, 60}, 6, -1);
        tick(10);
        check("ovf_flag", overflow_o, 1);
        check("ovf_valid", sample_valid_o, 1);
        check("ovf_done", done_cnt, 1);
        sample_ready_i = 1'b1;
        tick(6);
        check_got("ovf_keep", '{10, 20, 30, 40, 0, 0}, 4);
        check("ovf_sticky", overflow_o, 1);
        sample_ready_i = 1'b0;
        start_run();
        check("ovf_cleared", overflow_o, 0);
        check("ovf_restart_busy", busy_o, 1);
        stop_i = 1'b1;
        tick(1);
        stop_i = 1'b0;
        check("ovf_stop_busy", busy_o, 0);

        start_run();
        play_seq('{7, 9, 0, 0, 0, 0}, 2, -1);
        pwm_i = 1'b1;
        tick(50);
        pwm_i = 1'b0;
        tick(50);
        stop_i = 1'b1;
        tick(1);
        stop_i = 1'b0;
        check("stop_busy", busy_o, 0);
        tick(300);
        check("stop_no_done", done_cnt, 0);
        check("stop_valid", sample_valid_o, 1);
        sample_ready_i = 1'b1;
        tick(6);
        check_got("stop_keep", '{7, 9, 0, 0, 0, 0}, 2);
        sample_ready_i = 1'b0;

        start_run();
        play_seq('{3, 4, 0, 0, 0, 0}, 2, -1);
        pwm_i = 1'b1;
        tick(60);
        check("pre_rst_sample", sample_o, 3);
        #3 rst_ni = 1'b0;
        #1;
        check("mid_rst_sample", sample_o, 0);
        check("mid_rst_valid", sample_valid_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_ovf", overflow_o, 0);
        tick(2);
        rst_ni = 1'b1;
        pwm_i = 1'b0;
        tick(2);
        sample_ready_i = 1'b1;
        start_run();
        play_seq('{11, 22, 33, 44, 55, 66}, 6, -1);
        tick(10);
        check_got("post_rst", '{11, 22, 33, 44, 55, 66}, 6);
        check("post_rst_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
